// File: rtl/store_queue_pkg.sv
// store_queue_pkg: entry types, funct3 size codes and lane/byte-enable helpers for store_queue.
// Entry field widths fix the 32-bit word / 4-bit ROB tag datapath.
package store_queue_pkg;
  localparam int SQ_WORD_SIZE = 32;
  localparam int SQ_ROB_W = 4;
  localparam int SQ_BE_W = SQ_WORD_SIZE / 8;
  localparam logic [2:0] SQ_SZ_B = 3'b000;
  localparam logic [2:0] SQ_SZ_H = 3'b001;
  localparam logic [2:0] SQ_SZ_W = 3'b010;
  typedef enum logic [1:0] {
    SQ_FREE      = 2'd0,
    SQ_PENDING   = 2'd1,
    SQ_COMMITTED = 2'd2
  } sq_state_e;
  typedef struct packed {
    sq_state_e               state;
    logic [SQ_WORD_SIZE-1:0] addr;
    logic [SQ_WORD_SIZE-1:0] data;
    logic [SQ_BE_W-1:0]      be;
    logic [SQ_ROB_W-1:0]     rob_id;
  } sq_entry_t;
  function automatic logic [SQ_BE_W-1:0] sq_be(input logic [1:0] size, input logic [1:0] off);
    logic [SQ_BE_W-1:0] m;
    m = (size == SQ_SZ_B[1:0]) ? 4'b0001 : (size == SQ_SZ_H[1:0]) ? 4'b0011 : 4'b1111;
    return m << off;
  endfunction
  function automatic logic [SQ_WORD_SIZE-1:0] sq_lane(input logic [SQ_WORD_SIZE-1:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction
endpackage

// File: rtl/sq_fwd_unit.sv
// sq_fwd_unit: per-byte youngest-match select of queued store bytes for a probing load.
// Walks entries oldest to youngest from head so later matches override earlier ones.
module sq_fwd_unit
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sq_entry_t                 i_q [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  i_head,
  input  logic [SQ_WORD_SIZE-1:0]   i_addr,
  input  logic [SQ_BE_W-1:0]        i_be,
  output logic [SQ_BE_W-1:0]        o_found,
  output logic [SQ_WORD_SIZE-1:0]   o_data
);
  localparam int PW = $clog2(DEPTH);
  logic w_unused;
  always_comb begin
    o_found = '0;
    o_data = '0;
    w_unused = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_unused = w_unused ^ (^i_q[k].rob_id);
      for (int b = 0; b < SQ_BE_W; b++)
        if (i_q[i_head + PW'(k)].state != SQ_FREE && i_q[i_head + PW'(k)].addr == i_addr &&
            i_q[i_head + PW'(k)].be[b] && i_be[b]) begin
          o_found[b] = 1'b1;
          o_data[8*b +: 8] = i_q[i_head + PW'(k)].data[8*b +: 8];
        end
    end
  end
endmodule

// File: rtl/store_queue.sv
// store_queue: speculative store queue, in-order drain of committed stores to the data cache.
// Define STORE_QUEUE_FWD_EN for byte forwarding; otherwise any overlap stalls the load.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH = 4,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [WORD_SIZE-1:0]         alloc_addr,
  input  logic [WORD_SIZE-1:0]         alloc_data,
  input  logic [2:0]                   alloc_size,
  input  logic [ROB_ENTRY_WIDTH-1:0]   alloc_rob_id,
  input  logic                         commit_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]   commit_rob_id,
  input  logic                         flush,
  output logic                         drain_valid,
  input  logic                         drain_ready,
  output logic [WORD_SIZE-1:0]         drain_addr,
  output logic [WORD_SIZE-1:0]         drain_data,
  output logic [WORD_SIZE/8-1:0]       drain_be,
  input  logic                         ld_valid,
  input  logic [WORD_SIZE-1:0]         ld_addr,
  input  logic [2:0]                   ld_size,
  output logic                         ld_fwd_hit,
  output logic [WORD_SIZE-1:0]         ld_fwd_data,
  output logic                         ld_stall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = WORD_SIZE / 8;
  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_BUSY = 1'b1;
  sq_entry_t r_q [DEPTH];
  logic [PW:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [0:0] r_dstate;
  logic [WORD_SIZE-1:0] r_daddr, r_ddata;
  logic [BW-1:0] r_dbe;
  logic [PW-1:0] w_hidx, w_tidx;
  logic [DEPTH-1:0] w_cm;
  logic [CW-1:0] w_ncomm;
  logic w_full, w_push, w_pop, w_unused;
  logic [WORD_SIZE-1:0] w_ldaddr;
  logic [BW-1:0] w_ldbe, w_found;
  assign w_hidx = r_head[PW-1:0];
  assign w_tidx = r_tail[PW-1:0];
  assign w_full = (w_hidx == w_tidx) && (r_head[PW] != r_tail[PW]);
  assign alloc_ready = !w_full;
  assign w_push = alloc_valid && !w_full && !flush;
  assign w_pop = (r_dstate == D_BUSY) && drain_ready;
  assign count = r_count;
  assign empty = (r_count == '0);
  assign drain_valid = (r_dstate == D_BUSY);
  assign drain_addr = r_daddr;
  assign drain_data = r_ddata;
  assign drain_be = r_dbe;
  assign w_unused = ^{alloc_size[2], ld_size[2]};
  // w_ncomm counts entries that are committed once this cycle's commit lands
  always_comb begin
    w_cm = '0;
    w_ncomm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cm[i] = commit_valid && r_q[i].state == SQ_PENDING && r_q[i].rob_id == commit_rob_id;
      w_ncomm = w_ncomm + CW'(w_cm[i] || r_q[i].state == SQ_COMMITTED);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        if (w_pop && PW'(i) == w_hidx) r_q[i].state <= SQ_FREE;
        else if (w_cm[i]) r_q[i].state <= SQ_COMMITTED;
        else if (flush && r_q[i].state == SQ_PENDING) r_q[i].state <= SQ_FREE;
        else if (w_push && PW'(i) == w_tidx)
          r_q[i] <= '{SQ_PENDING, {alloc_addr[WORD_SIZE-1:2], 2'b00}, sq_lane(alloc_data, alloc_addr[1:0]),
                      sq_be(alloc_size[1:0], alloc_addr[1:0]), alloc_rob_id};
  // committed entries are contiguous from head, so flush rewinds tail to their end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + (PW+1)'(w_pop);
      r_tail <= flush ? r_head + (PW+1)'(w_ncomm) : r_tail + (PW+1)'(w_push);
      r_count <= (flush ? w_ncomm : r_count + CW'(w_push)) - CW'(w_pop);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dstate <= D_IDLE;
      r_daddr <= '0;
      r_ddata <= '0;
      r_dbe <= '0;
    end else if (r_dstate == D_IDLE) begin
      if (r_q[w_hidx].state == SQ_COMMITTED) begin
        r_dstate <= D_BUSY;
        r_daddr <= r_q[w_hidx].addr;
        r_ddata <= r_q[w_hidx].data;
        r_dbe <= r_q[w_hidx].be;
      end
    end else if (drain_ready) r_dstate <= D_IDLE;
  assign w_ldaddr = {ld_addr[WORD_SIZE-1:2], 2'b00};
  assign w_ldbe = ld_valid ? sq_be(ld_size[1:0], ld_addr[1:0]) : '0;
`ifdef STORE_QUEUE_FWD_EN
  logic [WORD_SIZE-1:0] w_fwd_data;
  sq_fwd_unit #(.DEPTH(DEPTH)) u_fwd (
    .i_q(r_q),
    .i_head(w_hidx),
    .i_addr(w_ldaddr),
    .i_be(w_ldbe),
    .o_found(w_found),
    .o_data(w_fwd_data)
  );
  assign ld_fwd_hit = ld_valid && (w_found == w_ldbe);
  assign ld_stall = ld_valid && (|w_found) && (w_found != w_ldbe);
  assign ld_fwd_data = w_fwd_data;
`else
  always_comb begin
    w_found = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_q[i].state != SQ_FREE && r_q[i].addr == w_ldaddr) w_found = w_found | (r_q[i].be & w_ldbe);
  end
  assign ld_fwd_hit = 1'b0;
  assign ld_stall = ld_valid && (|w_found);
  assign ld_fwd_data = '0;
`endif
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed self-checking bench for store_queue (default or STORE_QUEUE_FWD_EN build).
module tb_store_queue;
`ifdef STORE_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic alloc_valid = 1'b0, alloc_ready;
  logic [31:0] alloc_addr = '0, alloc_data = '0;
  logic [2:0] alloc_size = '0;
  logic [3:0] alloc_rob_id = '0;
  logic commit_valid = 1'b0;
  logic [3:0] commit_rob_id = '0;
  logic flush = 1'b0;
  logic drain_valid, drain_ready = 1'b0;
  logic [31:0] drain_addr, drain_data;
  logic [3:0] drain_be;
  logic ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0] ld_size = '0;
  logic ld_fwd_hit, ld_stall;
  logic [31:0] ld_fwd_data;
  logic [2:0] count;
  logic empty;
  int total = 0, bad = 0;
  logic [31:0] qa[$], qd[$];
  logic [3:0] qt[$];

  store_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .alloc_data(alloc_data), .alloc_size(alloc_size), .alloc_rob_id(alloc_rob_id),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .flush(flush),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_be(drain_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s, input logic [3:0] t);
    alloc_valid = 1'b1;
    alloc_addr = a;
    alloc_data = d;
    alloc_size = s;
    alloc_rob_id = t;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] t);
    commit_valid = 1'b1;
    commit_rob_id = t;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
    int n = 0;
    while (!drain_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(drain_valid), 1);
    chk({tag, ".addr"}, drain_addr, ea);
    chk({tag, ".data"}, drain_data, ed);
    chk({tag, ".be"}, 32'(drain_be), 32'hF);
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
  endtask

  task automatic ld_chk(input string tag, input logic [31:0] a, input logic [2:0] s,
                        input logic eh, input logic es, input logic [31:0] ed);
    ld_valid = 1'b1;
    ld_addr = a;
    ld_size = s;
    #1;
    chk({tag, ".hit"}, 32'(ld_fwd_hit), 32'(eh));
    chk({tag, ".stall"}, 32'(ld_stall), 32'(es));
    chk({tag, ".data"}, ld_fwd_data, ed);
    ld_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.ready", 32'(alloc_ready), 1);
    chk("rst.dvalid", 32'(drain_valid), 0);
    chk("rst.daddr", drain_addr, 0);
    chk("rst.ddata", drain_data, 0);
    chk("rst.dbe", 32'(drain_be), 0);
    chk("rst.hit", 32'(ld_fwd_hit), 0);
    chk("rst.stall", 32'(ld_stall), 0);

    alloc(32'h1000, 32'hDEADBEEF, 3'b010, 4'd3);
    chk("t1.count", 32'(count), 1);
    chk("t1.empty", 32'(empty), 0);
    commit(4'd3);
    chk("t1.dvalid0", 32'(drain_valid), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1.hold.valid", 32'(drain_valid), 1);
      chk("t1.hold.addr", drain_addr, 32'h1000);
      chk("t1.hold.data", drain_data, 32'hDEADBEEF);
      chk("t1.hold.be", 32'(drain_be), 32'hF);
      if (k < 3) tick();
    end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    chk("t1.dvalid_end", 32'(drain_valid), 0);
    chk("t1.empty_end", 32'(empty), 1);

    for (int k = 0; k < 4; k++) begin
      alloc(32'h100 + 32'(4 * k), 32'(k), 3'b010, 4'(k));
      qa.push_back(32'h100 + 32'(4 * k));
      qd.push_back(32'(k));
      qt.push_back(4'(k));
    end
    chk("t2.full.ready", 32'(alloc_ready), 0);
    chk("t2.full.count", 32'(count), 4);
    alloc(32'h900, 32'h99, 3'b010, 4'd4);
    chk("t2.drop.count", 32'(count), 4);
    commit(qt.pop_front());
    drain_one("t2.first", qa.pop_front(), qd.pop_front());
    chk("t2.ready_again", 32'(alloc_ready), 1);
    chk("t2.count3", 32'(count), 3);
    for (int j = 0; j < 9; j++) begin
      alloc(32'h200 + 32'(4 * j), 32'hC0DE0000 + 32'(j), 3'b010, 4'(4 + j));
      qa.push_back(32'h200 + 32'(4 * j));
      qd.push_back(32'hC0DE0000 + 32'(j));
      qt.push_back(4'(4 + j));
      commit(qt.pop_front());
      drain_one("t2.wrap", qa.pop_front(), qd.pop_front());
    end
    while (qt.size() > 0) begin
      commit(qt.pop_front());
      drain_one("t2.tail", qa.pop_front(), qd.pop_front());
    end
    chk("t2.empty", 32'(empty), 1);

    alloc(32'h2001, 32'hAA, 3'b000, 4'd1);
    alloc(32'h2000, 32'h11223344, 3'b010, 4'd2);
    alloc(32'h2002, 32'h55, 3'b000, 4'd3);
    ld_chk("t3.lw2000", 32'h2000, 3'b010, FWD, !FWD, FWD ? 32'h11553344 : 32'h0);
    ld_chk("t3.lh2006", 32'h2006, 3'b001, 1'b0, 1'b0, 32'h0);
    ld_addr = 32'h2000;
    ld_size = 3'b010;
    #1;
    chk("t3.noval.hit", 32'(ld_fwd_hit), 0);
    chk("t3.noval.stall", 32'(ld_stall), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3.flush.count", 32'(count), 0);

    alloc(32'h3000, 32'h7F, 3'b000, 4'd5);
    ld_chk("t4.lw3000", 32'h3000, 3'b010, 1'b0, 1'b1, 32'h0);
    ld_chk("t4.lb3000", 32'h3000, 3'b100, FWD, !FWD, FWD ? 32'h7F : 32'h0);
    ld_chk("t4.lb3001", 32'h3001, 3'b000, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4.flush.empty", 32'(empty), 1);

    alloc(32'h4000, 32'hA1, 3'b010, 4'd1);
    alloc(32'h4004, 32'hA2, 3'b010, 4'd2);
    alloc(32'h4008, 32'hA3, 3'b010, 4'd3);
    commit(4'd1);
    commit_valid = 1'b1;
    commit_rob_id = 4'd2;
    flush = 1'b1;
    alloc_valid = 1'b1;
    alloc_addr = 32'h400C;
    alloc_data = 32'hA4;
    alloc_size = 3'b010;
    alloc_rob_id = 4'd4;
    tick();
    commit_valid = 1'b0;
    flush = 1'b0;
    alloc_valid = 1'b0;
    chk("t5.count2", 32'(count), 2);
    drain_one("t5.e1", 32'h4000, 32'hA1);
    drain_one("t5.e2", 32'h4004, 32'hA2);
    chk("t5.count0", 32'(count), 0);
    chk("t5.empty", 32'(empty), 1);
    tick();
    tick();
    tick();
    chk("t5.no_more", 32'(drain_valid), 0);

    alloc(32'h5000, 32'hB6, 3'b010, 4'd6);
    alloc(32'h5004, 32'hB7, 3'b010, 4'd7);
    alloc(32'h5008, 32'hB8, 3'b010, 4'd8);
    commit(4'd6);
    for (int n = 0; n < 20 && !drain_valid; n++) tick();
    chk("t6.busy", 32'(drain_valid), 1);
    chk("t6.count3", 32'(count), 3);
    rst = 1'b1;
    tick();
    chk("t6.rst.dvalid", 32'(drain_valid), 0);
    chk("t6.rst.count", 32'(count), 0);
    chk("t6.rst.ready", 32'(alloc_ready), 1);
    rst = 1'b0;
    commit(4'd7);
    commit(4'd8);
    tick();
    tick();
    chk("t6.gone.dvalid", 32'(drain_valid), 0);
    chk("t6.gone.count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised, multi-entry store queue; successor to the single-path store buffer in the data-memory stage.
- Sits between the memory stage (TLB already translated) and the data cache write port.
- Holds speculative stores until the ROB commits them, then drains them in order to the cache with a valid/ready handshake.
- Forwards bytes to younger loads and discards uncommitted stores on flush.

Parameters:
- WORD_SIZE, 32, data/address width; multiple of 8.
- DEPTH, 4, number of entries; power of two, >= 2.
- ROB_ENTRY_WIDTH, 4, ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  insert store this cycle
- alloc_ready  out  1  queue can accept (= !full)
- alloc_addr  in  WORD_SIZE  physical address
- alloc_data  in  WORD_SIZE  store value, LSB-justified
- alloc_size  in  3  funct3: 000 byte, 001 half, 010 word
- alloc_rob_id  in  ROB_ENTRY_WIDTH  ROB tag
- commit_valid  in  1  ROB grants store permission
- commit_rob_id  in  ROB_ENTRY_WIDTH  tag being committed
- flush  in  1  discard all uncommitted entries
- drain_valid  out  1  committed store presented to cache
- drain_ready  in  1  cache accepted store (store_success)
- drain_addr  out  WORD_SIZE  word-aligned address
- drain_data  out  WORD_SIZE  lane-aligned data
- drain_be  out  WORD_SIZE/8  byte enables
- ld_valid  in  1  load probing the queue
- ld_addr  in  WORD_SIZE  load physical address
- ld_size  in  3  funct3 (bit 2 = unsigned, ignored here)
- ld_fwd_hit  out  1  all load bytes supplied by queue
- ld_fwd_data  out  WORD_SIZE  forwarded word, lane-aligned
- ld_stall  out  1  partial overlap; load must retry
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count == 0

Behaviour:
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits plus a wrap bit. Each entry holds state {FREE, PENDING, COMMITTED}, word address, lane-aligned data, byte enables, and rob_id.
- Reset: all entries FREE; head = tail = 0; count = 0; empty = 1; alloc_ready = 1; drain_valid = 0; drain_addr, drain_data and drain_be = 0; ld_fwd_hit = 0; ld_stall = 0.
- Alloc: when alloc_valid && alloc_ready, the entry at tail becomes PENDING, data is shifted to lane addr[1:0], and be is derived from size.
  - alloc_ready comes from registered count, so no alloc occurs when full even if a pop happens the same cycle.
  - Callers guarantee natural alignment.
- Commit: every PENDING entry whose rob_id equals commit_rob_id becomes COMMITTED. A non-matching tag is ignored. Commits arrive in program order, so COMMITTED entries are always a contiguous block starting at head.
- Drain FSM:
  - D_IDLE: if head is COMMITTED, register its addr/data/be into the drain_* outputs and go to D_BUSY.
  - D_BUSY: drain_valid = 1 and the outputs stay stable until drain_ready. On drain_ready, head is freed, head++, go to D_IDLE.
  - Throughput is one store per 2 cycles minimum; drain_ready while in D_IDLE is ignored.
- Flush: all PENDING entries become FREE and tail = head + committed count. COMMITTED entries and an in-flight drain are unaffected.
  - Same-cycle ordering: commit is applied before flush; flush wins over alloc (alloc is dropped).
- Forwarding (combinational):
  - For each byte of the load, select the youngest non-FREE entry with the same word address whose be covers that byte.
  - All bytes found: ld_fwd_hit = 1, ld_stall = 0.
  - Some bytes found: ld_fwd_hit = 0, ld_stall = 1.
  - No bytes found: both 0.
  - All three outputs are 0 when !ld_valid.
  - An entry in D_BUSY remains eligible until it is freed.
- Wrap-around: full when pointers are equal and wrap bits differ; empty when both are equal. count is updated with simultaneous +1/-1.
- Reset mid-drain discards everything, including the entry being drained.

Optional Feature:
- STORE_QUEUE_FWD_EN defined: forwarding as described above.
- Not defined: ld_fwd_hit and ld_fwd_data are tied to 0, and ld_stall = 1 on any byte overlap with any non-FREE entry. No forwarding mux is synthesised.

Decomposition:
- store_queue_pkg holds:
  - entry state enum;
  - entry struct;
  - funct3 size constants (SQ_SZ_B/H/W);
  - size+offset -> byte-enable function;
  - lane-align function.
- One sub-module: sq_fwd_unit, purely combinational per-byte youngest-match select over the entry array; instantiated only under STORE_QUEUE_FWD_EN.

Test Plan:
- Reset, then alloc sw 0x1000 = 0xDEADBEEF tag 3; commit 3 -> drain_valid after 1 cycle, addr 0x1000, data 0xDEADBEEF, be 1111; hold drain_ready low for 3 cycles -> outputs stable; ready -> empty = 1.
- Fill 4 entries -> alloc_ready = 0; a fifth alloc is dropped; commit and drain one -> alloc_ready = 1; continue 9 more allocs to exercise pointer wrap -> stores drain in FIFO order.
- Sequence: sb 0x2001 = 0xAA, then sw 0x2000 = 0x11223344, then sb 0x2002 = 0x55. Load lw 0x2000 -> fwd_hit = 1, data 0x11553344. Load lh 0x2006 -> no hit, no stall.
- sb 0x3000 = 0x7F only, then lw 0x3000 -> ld_stall = 1, fwd_hit = 0; with the macro undefined, lw 0x2000 in the previous case -> ld_stall = 1.
- Tags 1, 2, 3 allocated; commit 1; flush in the same cycle as commit 2 and an alloc of tag 4 -> entries 1 and 2 survive and drain; 3 and 4 are gone; count reaches 0.
- Assert rst while in D_BUSY with 3 entries -> next cycle drain_valid = 0, count = 0, alloc_ready = 1.
